// File: rtl/pwl_activation_lut_pkg.sv
// pwl_activation_pkg: helpers shared by the piecewise-linear activation blocks.
// Holds default widths, LUT depth / top-positive index helpers,
// segment next-index selection and signed saturation.
package pwl_activation_pkg;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_FRAC_W  = 4;
   localparam int DEF_DEPTH   = 1 << DEF_ADDR_W;
   localparam int DEF_TOP_POS = (1 << (DEF_ADDR_W - 1)) - 1;

   function automatic int lut_depth(int aw);
      return 1 << aw;
   endfunction

   function automatic int top_pos_idx(int aw);
      return (1 << (aw - 1)) - 1;
   endfunction

   // The -1 segment interpolates toward entry 0 so the curve is continuous
   // across zero; the top positive segment points at itself and saturates.
   function automatic int next_index(int idx, int aw);
      return idx == lut_depth(aw) - 1 ? 0 : idx == top_pos_idx(aw) ? idx : idx + 1;
   endfunction

   function automatic int clamp(int val, int dw);
      int lo = -(1 << (dw - 1));
      int hi = (1 << (dw - 1)) - 1;
      return val < lo ? lo : val > hi ? hi : val;
   endfunction
endpackage

// File: rtl/pwl_activation_lut_if.sv
// pwl_activation_lut_if: stream and LUT-configuration bundle of the activation unit.
// Ports: in_valid/in_ready/in_x (input stream), out_valid/out_ready/out_y
// (result stream), cfg_we/cfg_addr/cfg_data (LUT write port).
// master = producer/consumer/configurator side, slave = the activation unit.
interface pwl_activation_lut_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int FRAC_W = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [ADDR_W+FRAC_W-1:0]  in_x;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_y;
   logic                      cfg_we;
   logic [ADDR_W-1:0]         cfg_addr;
   logic [DATA_W-1:0]         cfg_data;

   modport master (
      output in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_y
   );

   modport slave (
      input  in_valid, in_x, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, out_y
   );
endinterface

// File: rtl/pwl_activation_lut_regfile.sv
// pwl_lut_regfile: breakpoint register array with one write and two read ports.
// Ports: clk, rst (sync clear of all entries), we_i/waddr_i/wdata_i (write),
// raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o (combinational reads).
module pwl_lut_regfile #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0] rdata_a_o,
   output logic [DATA_W-1:0] rdata_b_o
);
   logic [DATA_W-1:0] lut_q [1<<ADDR_W];

   always_ff @(posedge clk) begin
      if (rst) lut_q <= '{default: '0};
      else if (we_i) lut_q[waddr_i] <= wdata_i;
   end

   // Reads see the pre-edge contents, so a same-cycle write returns the old value.
   assign rdata_a_o = lut_q[raddr_a_i];
   assign rdata_b_o = lut_q[raddr_b_i];
endmodule

// File: rtl/pwl_activation_lut.sv
// pwl_activation_lut: 3-stage pipelined piecewise-linear activation with a loadable LUT.
// Ports: clk, rst (sync, active-high), bus (pwl_activation_lut_if.slave):
// valid/ready input stream in_x, valid/ready output stream out_y, cfg_* LUT writes.
module pwl_activation_lut
   import pwl_activation_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int FRAC_W = DEF_FRAC_W
)(
   input logic               clk,
   input logic               rst,
   pwl_activation_lut_if.slave bus
);
   localparam int IN_W = ADDR_W + FRAC_W;
   localparam int PW   = DATA_W + FRAC_W + 2;

   logic                     en;
   logic [ADDR_W-1:0]        idx, nidx;
   logic signed [DATA_W-1:0] base_d, next_d;
   logic signed [DATA_W:0]   diff;
   logic signed [PW-1:0]     prod_d, sum;
   logic signed [DATA_W-1:0] y_d;

   logic                     v1_q, v2_q, v3_q;
   logic signed [DATA_W-1:0] base1_q, next1_q, base2_q, y_q;
   logic [FRAC_W-1:0]        frac1_q;
   logic signed [PW-1:0]     prod2_q;

   // One global enable: the whole pipe advances only when the output slot frees up.
   assign en   = !v3_q || bus.out_ready;
   assign idx  = bus.in_x[IN_W-1 -: ADDR_W];
   assign nidx = ADDR_W'(next_index(int'(idx), ADDR_W));

   pwl_lut_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lut (
      .clk       (clk),
      .rst       (rst),
      .we_i      (bus.cfg_we),
      .waddr_i   (bus.cfg_addr),
      .wdata_i   (bus.cfg_data),
      .raddr_a_i (idx),
      .raddr_b_i (nidx),
      .rdata_a_o (base_d),
      .rdata_b_o (next_d)
   );

   always_comb begin
      diff   = {next1_q[DATA_W-1], next1_q} - {base1_q[DATA_W-1], base1_q};
      prod_d = PW'(diff) * $signed(PW'(frac1_q));
      sum    = PW'(base2_q) + (prod2_q >>> FRAC_W);
      y_d    = DATA_W'(clamp(int'(sum), DATA_W));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         base1_q <= '0;
         next1_q <= '0;
         frac1_q <= '0;
         base2_q <= '0;
         prod2_q <= '0;
         y_q     <= '0;
      end else if (en) begin
         v1_q    <= bus.in_valid;
         base1_q <= base_d;
         next1_q <= next_d;
         frac1_q <= bus.in_x[FRAC_W-1:0];
         v2_q    <= v1_q;
         base2_q <= base1_q;
         prod2_q <= prod_d;
         v3_q    <= v2_q;
         y_q     <= y_d;
      end
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = v3_q;
   assign bus.out_y     = y_q;
endmodule
